// File: rtl/axicb_rr_arbiter.sv
// rtl/axicb_rr_arbiter.sv - round-robin packet arbiter with grant locking until the last beat
module axicb_rr_arbiter #(
  parameter int REQ_NB = 4,
  parameter int ID_W   = 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              srst,
  input  logic [REQ_NB-1:0] req,
  input  logic              ack,
  input  logic              last,
  output logic [REQ_NB-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              grant_valid
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // One extra bit so ptr + offset can be folded back below REQ_NB without overflow.
  localparam logic [ID_W:0]     REQ_NB_X = (ID_W+1)'(REQ_NB);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(REQ_NB - 1);
  localparam logic [REQ_NB-1:0] ONE_HOT0 = REQ_NB'(1);

  state_t            state_q;
  state_t            state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic [REQ_NB-1:0] grant_d;
  logic [ID_W-1:0]   grant_id_d;
  logic              grant_valid_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   win_next;
  logic              release_pkt;

  // Search req starting at ptr and wrapping; the first set bit wins.
  always_comb begin
    logic [ID_W:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 0; i < REQ_NB; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= REQ_NB_X) begin
        cand = cand - REQ_NB_X;
      end
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Pointer after the winner, wrapping explicitly so non-power-of-2 counts stay in range.
  always_comb begin
    win_next = '0;
    if (win_id != LAST_ID) begin
      win_next = win_id + ID_W'(1);
    end
  end

  // Next-state and next-output decode: arbitrate from IDLE or on the release beat.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant;
    grant_id_d    = grant_id;
    grant_valid_d = grant_valid;
    release_pkt   = ack && last;

    case (state_q)
      ST_IDLE: begin
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
        if (win_found) begin
          state_d       = ST_LOCK;
          grant_d       = ONE_HOT0 << win_id;
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          ptr_d         = win_next;
        end
      end

      ST_LOCK: begin
        // The holder's req may drop mid-packet; only ack && last ends the lock.
        if (release_pkt) begin
          if (win_found) begin
            state_d       = ST_LOCK;
            grant_d       = ONE_HOT0 << win_id;
            grant_id_d    = win_id;
            grant_valid_d = 1'b1;
            ptr_d         = win_next;
          end else begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        ptr_d         = '0;
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs; srst clears exactly like areset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else if (srst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant       <= grant_d;
      grant_id    <= grant_id_d;
      grant_valid <= grant_valid_d;
    end
  end

endmodule

// File: tb/tb_axicb_rr_arbiter.sv
// tb/tb_axicb_rr_arbiter.sv - scoreboard bench for the round-robin packet arbiter
module tb_axicb_rr_arbiter;

  localparam int N = 4;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         srst = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic         last = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         grant_valid;

  typedef struct {
    int         due;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: who holds the grant (-1 = nobody) and where the search starts.
  int   m_holder = -1;
  int   m_ptr = 0;

  axicb_rr_arbiter #(.REQ_NB(N), .ID_W(2)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .srst        (srst),
    .req         (req),
    .ack         (ack),
    .last        (last),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic a, input logic l, input logic rst);
    int rv;
    int pick;
    int c;
    rv = int'(r);
    if (rst) begin
      m_holder = -1;
      m_ptr    = 0;
    end else if (m_holder < 0 || (a && l)) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (pick < 0 && ((rv >> c) & 1) != 0) pick = c;
      end
      m_holder = pick;
      if (pick >= 0) m_ptr = (pick + 1) % N;
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the coming edge.
  task automatic step(input logic [3:0] r, input logic a, input logic l,
                      input logic s, input logic ar);
    exp_t e;
    @(posedge aclk);
    #1;
    req    = r;
    ack    = a;
    last   = l;
    srst   = s;
    areset = ar;
    model_step(r, a, l, s || ar);
    e.due = cyc + 1;
    e.g   = (m_holder < 0) ? 4'd0 : 4'(1 << m_holder);
    e.id  = (m_holder < 0) ? 2'd0 : 2'(m_holder);
    e.v   = (m_holder >= 0);
    q.push_back(e);
  endtask

  // Outputs as they stand now, i.e. the result of the previous step's inputs.
  task automatic now_chk(input string name, input logic [3:0] g);
    check(name, grant, g);
    check({name, "_valid"}, grant_valid, (g != 4'd0));
  endtask

  // Monitor: compare DUT outputs against every scoreboard entry that falls due.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #2;
      while (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("sb_grant", grant, e.g);
        check("sb_grant_id", grant_id, e.id);
        check("sb_grant_valid", grant_valid, e.v);
      end
    end
  end

  initial begin
    logic [3:0] lk_req [9];
    logic       lk_ack [9];
    logic       lk_last[9];

    #2;
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_grant_valid", grant_valid, 0);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // ack && last in IDLE is ignored; srst beats a release in LOCK
    step(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("idle_ack_ignored", 4'b0000);
    step(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
    now_chk("first_grant", 4'b0001);
    step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("srst_in_lock", 4'b0000);
    step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("post_srst_grant", 4'b0001);

    // Fairness with single-beat packets
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("fair_cleared", 4'b0000);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
      now_chk("fair_rr", 4'(1 << (i % 4)));
    end

    // Lock: 4-beat packet to requester 1, its req drops mid-packet
    lk_req  = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
    lk_ack  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    lk_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      step(lk_req[j], lk_ack[j], lk_last[j], 1'b0, 1'b0);
      now_chk("lock_hold", (j < 8) ? 4'b0010 : 4'b0100);
    end

    // Skip and wrap from ptr = 3
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0);
    now_chk("wrap_setup", 4'b0100);
    step(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0);
    now_chk("wrap_to_0", 4'b0001);
    step(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("skip_to_2", 4'b0100);
    step(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0);
    now_chk("skip_hold", 4'b0100);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("wrap_again", 4'b0001);

    // Re-grant the same sole requester across back-to-back packets
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    now_chk("regrant_a", 4'b1000);
    step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
    now_chk("regrant_b", 4'b1000);
    step(4'b1000, 1'b1, 1'b1, 1'b0, 1'b0);
    now_chk("regrant_c", 4'b1000);
    step(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    now_chk("regrant_d", 4'b1000);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("release_to_idle", 4'b0000);

    // Asynchronous reset in the middle of a packet
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("areset_pre", 4'b0100);
    #2;
    areset = 1'b1;
    #1;
    check("areset_async_grant", grant, 0);
    check("areset_async_id", grant_id, 0);
    check("areset_async_valid", grant_valid, 0);
    q.delete();
    m_holder = -1;
    m_ptr    = 0;
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    now_chk("areset_first_grant", 4'b0001);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0), 1'b0);
    end

    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge aclk);
    #3;
    check("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
